alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU instance between two requesters (e.g. a main issue slot and a
//  secondary/microcoded slot). Each side has a valid/ready request and a valid/ready response channel.
//  Round-robin arbitration picks a winner. The winner's operands and control drive the ALU, and the
//  ALU result is captured in a single owner-tagged result register.
//  Sits in the execute stage between the requesters and the shared ALU.
// PARAMETERS
//  XLEN  64  operand/result width
//  CTLW  24  width of opaque ALU control bundle {W64,UW64,SubArith,ALUSelect,BSelect,ZBBSelect,Funct3,...}
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  reset_n      in   1     reset; asynchronous assert, active-low
//  Req0Valid    in   1     requester 0 has an operation
//  Req0Ready    out  1     requester 0 operation accepted this cycle (when Req0Valid=1)
//  Req0A/Req0B  in   XLEN  requester 0 operands
//  Req0Ctl      in   CTLW  requester 0 ALU control
//  Rsp0Valid    out  1     result for requester 0 available
//  Rsp0Ready    in   1     requester 0 consumes result
//  Rsp0Result   out  XLEN  result for requester 0
//  Req1*/Rsp1*  ...        identical set for requester 1
//  AluA/AluB    out  XLEN  operands to shared ALU
//  AluCtl       out  CTLW  control to shared ALU
//  AluResult    in   XLEN  combinational ALU result of AluA/AluB/AluCtl
// BEHAVIOUR
//  - Reset (reset_n=0, async): Full=0, Owner=0, LastGnt=1 (req0 wins first tie), ResultQ=0.
//    All Rsp*Valid=0, Req*Ready=0. An in-flight result is discarded; no response follows reset.
//  - States: EMPTY (Full=0) and HOLD (Full=1, result waiting for Owner's RspReady).
//  - Drain = Full & RspReady[Owner]. CanAccept = ~Full | Drain.
//  - Arbitration (combinational): one valid -> that requester wins. Both valid -> ~LastGnt wins.
//    Neither valid -> no grant. Gnt=winner & CanAccept.
//  - ReqReady[i] = Gnt[i]. It may depend combinationally on both ReqValid and on RspReady[Owner].
//    It never depends on ReqReady of the other side.
//  - AluA/AluB/AluCtl = granted requester's fields; all zeros when there is no grant.
//  - Accept (ReqValid[i]&ReqReady[i]) in cycle N:
//    ResultQ<=AluResult, Owner<=i, Full<=1, LastGnt<=i. RspValid[i]=1 from cycle N+1.
//    Latency 1 cycle. Throughput 1 op/cycle while the owner's RspReady is held 1.
//  - Drain without accept: Full<=0 next cycle. Drain and accept in the same cycle: Full stays 1,
//    and Owner/ResultQ are replaced by the new accept (back-to-back, no bubble).
//  - RspValid[i]=Full&(Owner==i). RspResult for both sides = ResultQ. Only Owner's Valid is meaningful.
//  - A non-owner side that keeps RspReady high has no effect.
//  - Protocol rules: a requester holds ReqValid and its fields stable until accepted.
//    An unaccepted request may not be withdrawn. Violations are caught by bench assertions.
//  - Starvation: with both valid every cycle and responses drained, grants alternate 0,1,0,1...
//  - HOLD with the owner stalled (RspReady=0): both ReqReady=0. The ALU inputs are zero.
// CONFIGURATION
//  - Macro ALU_ARB_PERFCNT_EN. When defined, adds these outputs:
//      GntCnt0 (32 bits), GntCnt1 (32 bits): accepts per requester.
//      ConflictCnt (32 bits): cycles with both ReqValid=1 where only one was granted, or none was
//      granted because the block was in HOLD with no drain.
//    The counters reset to 0, increment by 1, wrap at 2^32-1 -> 0, and add no logic to the datapath.
//  - Undefined: these ports still exist and are tied to 0, and no counter flops are built.
// TESTING
//  - Reset, then Req0Valid=1 with A=5, B=3 and Ctl=add. Required: Req0Ready=1 in the same cycle;
//    next cycle Rsp0Valid=1 and Rsp0Result=8; Rsp1Valid=0.
//  - Both valid every cycle, both RspReady=1, for 6 cycles. Required: accept order 0,1,0,1,0,1.
//    Each result arrives one cycle later with the correct Owner; no idle cycles.
//  - Owner 0 holds its result with Rsp0Ready=0 for 4 cycles while Req1Valid=1. Required: Req1Ready=0
//    and Rsp0Result stable. When Rsp0Ready=1, Req1 is accepted in that same cycle, and Rsp1Valid=1
//    follows the next cycle.
//  - Assert reset_n=0 mid-HOLD, asynchronously between edges. Required: Rsp*Valid drop immediately,
//    no stale response after release, and the first tie after reset goes to req0.
//  - With ALU_ARB_PERFCNT_EN defined, 10 accepts (7 req0, 3 req1) and 2 contention cycles.
//    Required: GntCnt0=7, GntCnt1=3, ConflictCnt=2. Preload to 32'hFFFF_FFFF and accept once ->
//    GntCnt reads 0. Without the macro, all three counters read 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. A round-robin arbiter
//   picks a winner among the valid requests. The winner's operands and control
//   drive the ALU. The ALU result is captured in one owner-tagged result register
//   and returned on that owner's response channel one cycle later.
//
//   Optional feature: define ALU_ARB_PERFCNT_EN to build the grant and conflict
//   counters. When it is undefined, the counter ports are tied to zero and no
//   counter flops are built.
module alu_share_arbiter #(
    parameter int XLEN = 64,
    parameter int CTLW = 24
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [XLEN-1:0] i_req0_a,
    input  logic [XLEN-1:0] i_req0_b,
    input  logic [CTLW-1:0] i_req0_ctl,
    output logic            o_rsp0_valid,
    input  logic            i_rsp0_ready,
    output logic [XLEN-1:0] o_rsp0_result,

    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [XLEN-1:0] i_req1_a,
    input  logic [XLEN-1:0] i_req1_b,
    input  logic [CTLW-1:0] i_req1_ctl,
    output logic            o_rsp1_valid,
    input  logic            i_rsp1_ready,
    output logic [XLEN-1:0] o_rsp1_result,

    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [CTLW-1:0] o_alu_ctl,
    input  logic [XLEN-1:0] i_alu_result,

    output logic [31:0]     o_gnt_cnt0,
    output logic [31:0]     o_gnt_cnt1,
    output logic [31:0]     o_conflict_cnt
);

    // EMPTY: no result is held. HOLD: a result waits for its owner's response ready.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_owner;     // requester that owns r_result
    logic            r_last_gnt;  // most recent winner; the other side wins the next tie
    logic [XLEN-1:0] r_result;

    logic w_full;
    logic w_owner_ready;
    logic w_drain;
    logic w_can_accept;
    logic w_both_valid;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;

    assign w_full        = (r_state == ST_HOLD);
    assign w_owner_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;
    assign w_drain       = w_full & w_owner_ready;
    // Nothing is granted while reset is asserted, so Ready stays low during reset.
    assign w_can_accept  = reset_n & (~w_full | w_drain);
    assign w_both_valid  = i_req0_valid & i_req1_valid;

    // On a tie the side that did not win last time is picked. Otherwise the only valid side is picked.
    assign w_pick1  = w_both_valid ? ~r_last_gnt : i_req1_valid;
    assign w_gnt0   = w_can_accept & i_req0_valid & ~w_pick1;
    assign w_gnt1   = w_can_accept & i_req1_valid &  w_pick1;
    assign w_accept = w_gnt0 | w_gnt1;

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // Route the granted requester to the shared ALU. The ALU inputs are zero when there is no grant.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        o_alu_a   = '0;
        o_alu_b   = '0;
        o_alu_ctl = '0;
        if (w_gnt0) begin
            o_alu_a   = i_req0_a;
            o_alu_b   = i_req0_b;
            o_alu_ctl = i_req0_ctl;
        end else if (w_gnt1) begin
            o_alu_a   = i_req1_a;
            o_alu_b   = i_req1_b;
            o_alu_ctl = i_req1_ctl;
        end
    end

    // Result-holding FSM. An accept always loads the register, including when the old result drains in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the result register is reset as well, so the response data reads zero after reset.
            r_state    <= ST_EMPTY;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_result   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the pre-edge values.
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state    <= ST_HOLD;
                        r_owner    <= w_gnt1;
                        r_last_gnt <= w_gnt1;
                        r_result   <= i_alu_result;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_owner    <= w_gnt1;
                        r_last_gnt <= w_gnt1;
                        r_result   <= i_alu_result;
                    end else if (w_drain) begin
                        r_state    <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_rsp0_valid  = w_full & ~r_owner;
    assign o_rsp1_valid  = w_full &  r_owner;
    assign o_rsp0_result = r_result;
    assign o_rsp1_result = r_result;

`ifdef ALU_ARB_PERFCNT_EN
    logic [31:0] r_gnt_cnt0;
    logic [31:0] r_gnt_cnt1;
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    // A conflict is a both-valid cycle that grants only one side, or grants neither because the result is stalled.
    assign w_conflict = w_both_valid & ((w_gnt0 ^ w_gnt1) | (w_full & ~w_drain));

    // Observation-only counters. They wrap at 2^32 and never feed back into the datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt_cnt0     <= '0;
            r_gnt_cnt1     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt0)     r_gnt_cnt0     <= r_gnt_cnt0 + 32'd1;
            if (w_gnt1)     r_gnt_cnt1     <= r_gnt_cnt1 + 32'd1;
            if (w_conflict) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign o_gnt_cnt0     = r_gnt_cnt0;
    assign o_gnt_cnt1     = r_gnt_cnt1;
    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_gnt_cnt0     = '0;
    assign o_gnt_cnt1     = '0;
    assign o_conflict_cnt = '0;
`endif

endmodule
